// File: rtl/mux16_arbiter_pkg.sv
// Shared constants for the mux16 round-robin arbiter.
package mux16_arbiter_pkg;

    localparam int WIDTH = 16;

    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    localparam logic [WIDTH-1:0] OUT_RST      = 16'h0000;
    localparam logic             LAST_SEL_RST = SEL_Y;

endpackage

// File: rtl/mux16_arbiter_mux16.sv
// mux16: 16-bit two-way data multiplexer; sel=0 passes x, sel=1 passes y.
module mux16
    import mux16_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? y : x;

endmodule

// File: rtl/mux16_arbiter.sv
// mux16_arbiter: two-requester round-robin arbiter with a single-entry
// registered output stage in front of the shared 16-bit consumer bus.
// Optional grant counters are built when MUX16_ARBITER_GRANT_CNT_EN is defined.
module mux16_arbiter
    import mux16_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    input  logic             y_valid,
    input  logic [WIDTH-1:0] y_data,
    output logic             y_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
`ifdef MUX16_ARBITER_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] x_cnt,
    output logic [CNT_W-1:0] y_cnt
`endif
);

    logic             last_sel;
    logic             grant;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] data_mux;

    // Round-robin grant: a lone requester wins, a tie goes to the one not
    // served last, and with no requester the select parks on last_sel.
    always_comb begin
        // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
        grant = last_sel;
        case ({x_valid, y_valid})
            2'b10:   grant = SEL_X;
            2'b01:   grant = SEL_Y;
            2'b11:   grant = ~last_sel;
            default: grant = last_sel;
        endcase
    end

    // The register can take a word when empty or being drained; never while
    // in reset, so nothing is acknowledged that the reset would then discard.
    assign load    = !reset && (!out_valid || out_ready);
    assign x_ready = load && x_valid && (grant == SEL_X);
    assign y_ready = load && y_valid && (grant == SEL_Y);
    assign take    = x_ready || y_ready;
    assign sel     = grant;

    mux16 u_mux16 (
        .x   (x_data),
        .y   (y_data),
        .sel (sel),
        .out (data_mux)
    );

    // Output register: load on accept, drop valid on drain, hold under backpressure.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= OUT_RST;
            out_src   <= SEL_X;
            last_sel  <= LAST_SEL_RST;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= data_mux;
            out_src   <= sel;
            last_sel  <= sel;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX16_ARBITER_GRANT_CNT_EN
    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            if (x_ready && (x_cnt != {CNT_W{1'b1}})) x_cnt <= x_cnt + 1'b1;
            if (y_ready && (y_cnt != {CNT_W{1'b1}})) y_cnt <= y_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux16_arbiter.md
Name: mux16_arbiter

Overview:
Two-requester round-robin arbiter and output stage for the 16-bit two-way mux datapath. Requesters X and Y present 16-bit words with valid/ready handshakes. The block drives the mux select, registers the selected word into a single-entry output register and hands it downstream with valid/ready. It sits between two 16-bit producers and one shared 16-bit consumer bus.

Parameters:
WIDTH, 16, data width; fixed at 16 to match mux16, no other value supported.
CNT_W, 8, width of the per-requester grant counters (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
x_valid  input  1  requester X has a word.
x_data  input  16  requester X word.
x_ready  output  1  X word accepted this cycle.
y_valid  input  1  requester Y has a word.
y_data  input  16  requester Y word.
y_ready  output  1  Y word accepted this cycle.
sel  output  1  current mux select; 0 selects X, 1 selects Y.
out_valid  output  1  output register holds a word.
out_data  output  16  registered word.
out_src  output  1  source of out_data; 0 means X, 1 means Y.
out_ready  input  1  downstream accepts out_data.
x_cnt  output  CNT_W  X grant count (present only with the optional feature).
y_cnt  output  CNT_W  Y grant count (present only with the optional feature).

Behaviour:
- Reset values (synchronous, on the clk edge with reset=1):
  - out_valid=0, out_data=16'h0000, out_src=0.
  - last_sel=1, so X wins the first tie.
  - Counters=0.
- Reset overrides all other activity in the same cycle. A word in flight is discarded and no ready is asserted during reset.
- load = !out_valid || out_ready. The output register can take a new word this cycle.
- Grant (combinational):
  - Only x_valid set: grant X.
  - Only y_valid set: grant Y.
  - Both set: grant !last_sel (round robin).
  - Neither set: sel holds last_sel.
- sel = grant. Drives the mux16 select; data_mux = sel ? y_data : x_data.
- Ready outputs:
  - x_ready = load && x_valid && (grant==0).
  - y_ready = load && y_valid && (grant==1).
  - At most one ready is high in any cycle. Readies never depend on out_valid of the same requester.
- Transfer in on the clk edge when (x_ready||y_ready):
  - out_data <= data_mux, out_src <= sel, out_valid <= 1, last_sel <= sel.
- Transfer out when out_valid && out_ready. With no transfer in that cycle, out_valid <= 0 and out_data holds its value.
- Simultaneous out and in in one cycle: the register is replaced. Throughput is 1 word/cycle, latency is 1 cycle from accept to out_valid.
- Backpressure (out_valid=1, out_ready=0): both readies stay 0. out_data, out_src and out_valid are held stable. last_sel is not updated.
- Requester valid dropping without a handshake is legal. The grant is re-evaluated every cycle, with no lock.
- Starvation bound: under continuous contention and out_ready=1, the grants alternate X,Y,X,Y.

Optional Feature:
Macro MUX16_ARBITER_GRANT_CNT_EN.
- Defined: the x_cnt/y_cnt ports exist. Each counter increments by 1 on every accepted word from its requester and saturates at 2^CNT_W-1 (no wrap). Counters clear on reset.
- Undefined: the counter ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package mux16_arbiter_pkg:
  - WIDTH=16.
  - SEL_X=1'b0, SEL_Y=1'b1.
  - Reset constants OUT_RST=16'h0000 and LAST_SEL_RST=SEL_Y.
- Sub-module: instantiate the existing mux16 (x, y, sel, out) for the data selection. The arbiter adds only the grant logic, the output register and the optional counters.

Test Plan:
1. Reset, then x_valid=1, x_data=16'h1234, y_valid=0, out_ready=1 -> x_ready=1, sel=0. Next cycle out_valid=1, out_data=16'h1234, out_src=0.
2. Both valid every cycle, x_data=16'h0000, y_data=16'h5555, out_ready=1 -> out_src sequence 0,1,0,1 and out_data 0000,5555,0000,5555. Only one ready high per cycle.
3. Word held (out_valid=1) with out_ready=0 for 3 cycles, x_data=16'h9112 pending -> x_ready=y_ready=0. out_data stays stable. On out_ready=1, 16'h9112 is loaded the same cycle.
4. Both valid with y_data=16'hFFFF; assert reset for 1 cycle with out_valid=1 -> out_valid=0, out_data=0. In the first post-reset cycle X is granted (sel=0).
5. Only y_valid, y_data=16'h5555, with out_valid=0 -> y_ready=1, sel=1. Next out_data=16'h5555, out_src=1.
6. MUX16_ARBITER_GRANT_CNT_EN defined, CNT_W=2, 5 X grants -> x_cnt=1,2,3,3,3 (saturates). y_cnt=0.
